ps2_arrow_tracker: RTL and testbench
====================================

// Module: ps2_arrow_tracker
// PURPOSE
//   Sequential successor to the combinational arrow-key decoder. Consumes a raw PS/2 set-2 byte
//   stream, parses E0 (extended) and F0 (break) prefixes, and keeps registered held levels for
//   the four arrow keys. Emits a one-cycle event per make/break. Sits between the PS/2 byte
//   receiver and game/UI control logic.
// PARAMETERS
//   LEFT_CODE        8'h6B  extended code for left
//   DOWN_CODE        8'h72  extended code for down
//   RIGHT_CODE       8'h74  extended code for right
//   UP_CODE          8'h75  extended code for up
//   TIMEOUT_CYCLES   1000   idle cycles mid-sequence before the parser aborts (>=2)
//   SUPPRESS_REPEAT  1      1: typematic make of an already-held key gives no event
// PORTS
//   clk          in   1  clock, all state on rising edge
//   areset_n     in   1  asynchronous, active-low reset
//   byte_in      in   8  received PS/2 byte
//   byte_valid   in   1  byte_in valid this cycle (single-cycle strobe per byte)
//   left         out  1  left arrow held
//   down         out  1  down arrow held
//   right        out  1  right arrow held
//   up           out  1  up arrow held
//   key_event    out  1  one-cycle pulse: make/break of an arrow key accepted
//   key_id       out  2  0=left 1=down 2=right 3=up; valid with key_event
//   key_make     out  1  1=make, 0=break; valid with key_event
//   timeout_err  out  1  one-cycle pulse: sequence aborted by timeout
// BEHAVIOUR
//   Reset: state IDLE, timeout counter 0, all outputs 0.
//   FSM (advances only on byte_valid, except timeout):
//     IDLE:    E0->EXT; F0->BRK; other->IDLE (non-extended make, ignored)
//     EXT:     F0->EXT_BRK; E0->EXT; arrow code->make, IDLE; other->IDLE, ignored
//     BRK:     E0->EXT; F0->BRK; other->IDLE (non-extended break, ignored)
//     EXT_BRK: E0->EXT; F0->EXT_BRK; arrow code->break, IDLE; other->IDLE, ignored
//   Make: held bit set; key_event=1, key_make=1, key_id set. With SUPPRESS_REPEAT=1 and bit
//     already 1: no event, level unchanged. With SUPPRESS_REPEAT=0: event on every make.
//   Break: held bit cleared; key_event=1, key_make=0. Break of a key not held still pulses.
//   Latency: level and event registered; visible the cycle after the final byte is strobed.
//   key_id/key_make hold last value between events; only meaningful with key_event.
//   Non-extended arrow codes (numpad 6B/72/74/75 without E0) never affect outputs.
//   Multiple arrows may be held at once; each bit is independent.
//   Timeout: counter clears on every byte_valid and in IDLE; counts while state != IDLE.
//     Reaching TIMEOUT_CYCLES-1 with no byte: state->IDLE, timeout_err pulses, levels kept.
//     byte_valid in the timeout cycle wins: byte processed normally, no timeout_err.
//   Counter width $clog2(TIMEOUT_CYCLES); saturates, never wraps.
//   Reset mid-sequence: async clear to reset values; the partial sequence is discarded.
// TESTING
//   E0,6B -> left=1, key_event pulse, key_id=0, key_make=1, one cycle after 6B strobe.
//   E0,6B,E0,6B (SUPPRESS_REPEAT=1) -> exactly one key_event; E0,F0,6B -> left=0, event key_make=0.
//   E0,75 then E0,74 -> up=1 and right=1 together; E0,F0,75 -> up=0, right stays 1.
//   6B alone; F0,72 -> no outputs change, no key_event; FSM returns to IDLE.
//   E0 then TIMEOUT_CYCLES idle cycles -> timeout_err pulse; next 6B ignored (left stays 0).
//   E0,F0 then areset_n=0 mid-sequence -> all outputs 0; after release, 72 alone has no effect.

Source files
------------

// File: rtl/ps2_arrow_tracker.sv
// Tracks the held state of the four PS/2 set-2 arrow keys from a raw byte stream and flags each make/break.
// Latency: levels and events are registered and appear one cycle after the final byte is strobed.
// Backpressure: none; every strobed byte is consumed the cycle it arrives.
module ps2_arrow_tracker #(
    parameter logic [7:0] LEFT_CODE       = 8'h6B,
    parameter logic [7:0] DOWN_CODE       = 8'h72,
    parameter logic [7:0] RIGHT_CODE      = 8'h74,
    parameter logic [7:0] UP_CODE         = 8'h75,
    parameter int         TIMEOUT_CYCLES  = 1000,
    parameter bit         SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       left,
    output logic       down,
    output logic       right,
    output logic       up,
    output logic       key_event,
    output logic [1:0] key_id,
    output logic       key_make,
    output logic       timeout_err
);

    localparam int            CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    PFX_EXT  = 8'hE0;
    localparam logic [7:0]    PFX_BRK  = 8'hF0;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    held, held_nxt;     // bit index matches key_id encoding
    logic          evt_nxt, make_nxt, to_nxt;
    logic [1:0]    id_nxt;
    logic          arrow_hit;
    logic [1:0]    arrow_id;

    always_comb begin
        arrow_hit = 1'b1;
        arrow_id  = 2'd0;
        case (byte_in)
            LEFT_CODE:  arrow_id = 2'd0;
            DOWN_CODE:  arrow_id = 2'd1;
            RIGHT_CODE: arrow_id = 2'd2;
            UP_CODE:    arrow_id = 2'd3;
            default:    arrow_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        held_nxt  = held;
        evt_nxt   = 1'b0;
        to_nxt    = 1'b0;
        id_nxt    = key_id;
        make_nxt  = key_make;
        if (byte_valid) begin
            cnt_nxt = '0;
            if (byte_in == PFX_EXT) begin
                state_nxt = EXT;
            end else if (byte_in == PFX_BRK) begin
                state_nxt = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
            end else begin
                state_nxt = IDLE;
                if (arrow_hit && state == EXT) begin
                    held_nxt[arrow_id] = 1'b1;
                    if (!(SUPPRESS_REPEAT && held[arrow_id])) begin
                        evt_nxt  = 1'b1;
                        id_nxt   = arrow_id;
                        make_nxt = 1'b1;
                    end
                end else if (arrow_hit && state == EXT_BRK) begin
                    held_nxt[arrow_id] = 1'b0;
                    evt_nxt  = 1'b1;
                    id_nxt   = arrow_id;
                    make_nxt = 1'b0;
                end
            end
        end else if (state != IDLE) begin
            // A stalled prefix is abandoned; held levels are deliberately left alone.
            if (cnt == CNT_LAST) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                to_nxt    = 1'b1;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end else begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            held        <= '0;
            key_event   <= 1'b0;
            key_id      <= 2'd0;
            key_make    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            held        <= held_nxt;
            key_event   <= evt_nxt;
            key_id      <= id_nxt;
            key_make    <= make_nxt;
            timeout_err <= to_nxt;
        end
    end

    assign left  = held[0];
    assign down  = held[1];
    assign right = held[2];
    assign up    = held[3];

endmodule

// File: tb/tb_ps2_arrow_tracker.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops and compares them.
module tb_ps2_arrow_tracker;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       areset_n = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       left, down, right, up, key_event, key_make, timeout_err;
    logic [1:0] key_id;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit         is_to;
        logic [1:0] id;
        logic       make;
    } exp_t;
    exp_t exp_q[$];

    ps2_arrow_tracker #(.TIMEOUT_CYCLES(T), .SUPPRESS_REPEAT(1'b1)) dut (
        .clk(clk), .areset_n(areset_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .left(left), .down(down), .right(right), .up(up),
        .key_event(key_event), .key_id(key_id), .key_make(key_make), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic push_evt(input logic [1:0] id, input logic make);
        exp_t e;
        e.is_to = 1'b0;
        e.id    = id;
        e.make  = make;
        exp_q.push_back(e);
    endtask

    task automatic push_to();
        exp_t e;
        e.is_to = 1'b1;
        e.id    = 2'd0;
        e.make  = 1'b0;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (areset_n && (key_event || timeout_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {6'd0, key_event, timeout_err}, 8'h00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_to) begin
                    chk("sb_timeout_err", {7'd0, timeout_err}, 8'h01);
                    chk("sb_timeout_no_event", {7'd0, key_event}, 8'h00);
                end else begin
                    chk("sb_key_event", {7'd0, key_event}, 8'h01);
                    chk("sb_key_id", {6'd0, key_id}, {6'd0, e.id});
                    chk("sb_key_make", {7'd0, key_make}, {7'd0, e.make});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_levels", {4'd0, up, right, down, left}, 8'h00);
        chk("rst_event", {6'd0, key_event, timeout_err}, 8'h00);
        chk("rst_id_make", {5'd0, key_id, key_make}, 8'h00);
        areset_n = 1'b1;
        @(negedge clk);

        // make left, then typematic repeat, then break
        push_evt(2'd0, 1'b1);
        send(8'hE0); send(8'h6B);
        chk("left_make", {7'd0, left}, 8'h01);
        send(8'hE0); send(8'h6B);
        chk("left_repeat_level", {7'd0, left}, 8'h01);
        push_evt(2'd0, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("left_break", {7'd0, left}, 8'h00);

        // two keys held independently
        push_evt(2'd3, 1'b1);
        send(8'hE0); send(8'h75);
        push_evt(2'd2, 1'b1);
        send(8'hE0); send(8'h74);
        chk("up_right_held", {4'd0, up, right, down, left}, 8'h0C);
        push_evt(2'd3, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_break_right_kept", {4'd0, up, right, down, left}, 8'h04);

        // numpad (non-extended) make/break ignored; key_id/key_make hold
        send(8'h6B);
        send(8'hF0); send(8'h72);
        chk("numpad_levels", {4'd0, up, right, down, left}, 8'h04);
        chk("numpad_id_hold", {5'd0, key_id, key_make}, {5'd0, 2'd3, 1'b0});
        // FSM back in IDLE: a bare arrow code is still ignored
        send(8'h74);
        chk("idle_after_numpad", {4'd0, up, right, down, left}, 8'h04);

        // break of a key not held still pulses
        push_evt(2'd1, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h72);
        chk("break_not_held", {7'd0, down}, 8'h00);

        // EXT_BRK -> E0 returns to EXT (make); BRK -> E0 also reaches EXT
        push_evt(2'd1, 1'b1);
        send(8'hE0); send(8'hF0); send(8'hE0); send(8'h72);
        chk("extbrk_e0_make", {7'd0, down}, 8'h01);
        push_evt(2'd0, 1'b1);
        send(8'hF0); send(8'hE0); send(8'h6B);
        chk("brk_e0_make", {7'd0, left}, 8'h01);
        push_evt(2'd0, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("left_break2", {4'd0, up, right, down, left}, 8'h06);

        // timeout after T idle cycles; levels kept, next bare code ignored
        send(8'hE0);
        repeat (T - 1) @(negedge clk);
        chk("no_timeout_early", {7'd0, timeout_err}, 8'h00);
        push_to();
        @(negedge clk);
        chk("timeout_levels_kept", {4'd0, up, right, down, left}, 8'h06);
        send(8'h6B);
        chk("after_timeout_ignored", {7'd0, left}, 8'h00);

        // byte arriving in the timeout cycle wins
        send(8'hE0);
        repeat (T - 1) @(negedge clk);
        push_evt(2'd0, 1'b1);
        send(8'h6B);
        chk("byte_beats_timeout", {7'd0, left}, 8'h01);
        repeat (3) @(negedge clk);

        // reset mid-sequence discards the prefix
        send(8'hE0); send(8'hF0);
        areset_n = 1'b0;
        #2;
        chk("midrst_levels", {4'd0, up, right, down, left}, 8'h00);
        chk("midrst_outputs", {5'd0, key_event, key_make, timeout_err}, 8'h00);
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        send(8'h72);
        chk("after_rst_72", {4'd0, up, right, down, left}, 8'h00);

        repeat (4) @(negedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
